truth_table_checker: RTL and testbench



---
 rtl/truth_table_checker_pkg.sv | 11 +
 rtl/truth_table_checker_if.sv | 24 ++
 rtl/truth_table_checker_settle_timer.sv | 19 +
 rtl/truth_table_checker.sv | 69 ++++++
 tb/tb_truth_table_checker.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/truth_table_checker_pkg.sv
// truth_table_checker_pkg: shared FSM state encoding and default parameters
//   for the exhaustive 4-input truth-table checker.
package tt_check_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
   localparam int N_IN_DEF   = 4;
   localparam int SETTLE_DEF = 10;
endpackage

// File: rtl/truth_table_checker_if.sv
// truth_table_checker_if: bundles control, DUT stimulus/response and result signals.
//   master: host/bench side (drives start, expected, dut_out)
//   slave : checker side (drives vec_out and all result outputs)
interface truth_table_checker_if #(parameter int N_IN = 4);
   logic                 start;
   logic [2**N_IN-1:0]   expected;
   logic                 dut_out;
   logic [N_IN-1:0]      vec_out;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [N_IN:0]        fail_count;
   logic [N_IN-1:0]      first_fail;
   logic                 first_fail_valid;
   logic [2**N_IN-1:0]   captured;
   modport master (
      output start, expected, dut_out,
      input  vec_out, busy, done, pass, fail_count, first_fail, first_fail_valid, captured
   );
   modport slave (
      input  start, expected, dut_out,
      output vec_out, busy, done, pass, fail_count, first_fail, first_fail_valid, captured
   );
endinterface

// File: rtl/truth_table_checker_settle_timer.sv
// settle_timer: counts 0..SETTLE-1 while enabled and flags the last count.
//   clk, nrst (sync active-low), clear (sync zero), en (count), tick (count == SETTLE-1)
module settle_timer #(
   parameter int SETTLE = 10
) (
   input  logic clk,
   input  logic nrst,
   input  logic clear,
   input  logic en,
   output logic tick
);
   localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   logic [W-1:0] r_cnt;
   assign tick = (r_cnt == W'(SETTLE - 1));
   always_ff @(posedge clk) begin
      if (!nrst || clear) r_cnt <= '0;
      else if (en)        r_cnt <= tick ? '0 : r_cnt + W'(1);
   end
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: steps a vector through all 2**N_IN codes, samples the DUT
//   response after each settle period and compares it with an expected table.
//   clk, nrst (sync active-low); bus: start/expected/dut_out in, vec_out and results out
module truth_table_checker
   import tt_check_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic                   clk,
   input  logic                   nrst,
   truth_table_checker_if.slave   bus
);
   state_t                r_state, w_next;
   logic [N_IN-1:0]       r_vec;
   logic [2**N_IN-1:0]    r_cap;
   logic [N_IN:0]         r_fail;
   logic [N_IN-1:0]       r_ff;
   logic                  r_ffv;
   logic                  w_tick, w_last, w_miss, w_run;
   assign w_run  = (r_state == RUN);
   assign w_last = (r_vec == {N_IN{1'b1}});
   assign w_miss = (bus.dut_out != bus.expected[r_vec]);
   settle_timer #(.SETTLE(SETTLE)) u_timer (
      .clk   (clk),
      .nrst  (nrst),
      .clear (!w_run),
      .en    (w_run),
      .tick  (w_tick)
   );
   always_ff @(posedge clk) begin
      if (!nrst) r_state <= IDLE;
      else       r_state <= w_next;
   end
   // start is only honoured outside RUN; an unused encoding falls back to IDLE
   always_comb begin
      w_next = IDLE;
      w_next = w_run ? ((w_tick && w_last) ? DONE : RUN)
             : bus.start ? RUN
             : (r_state == DONE) ? DONE : IDLE;
   end
   always_ff @(posedge clk) begin
      if (!nrst || (!w_run && bus.start)) begin
         r_vec  <= '0;
         r_cap  <= '0;
         r_fail <= '0;
         r_ff   <= '0;
         r_ffv  <= 1'b0;
      end else if (w_run && w_tick) begin
         r_cap[r_vec] <= bus.dut_out;
         if (w_miss) begin
            r_fail <= r_fail + (N_IN+1)'(1);
            if (!r_ffv) begin
               r_ff  <= r_vec;
               r_ffv <= 1'b1;
            end
         end
         if (!w_last) r_vec <= r_vec + N_IN'(1);
      end
   end
   assign bus.vec_out          = r_vec;
   assign bus.busy             = w_run;
   assign bus.done             = (r_state == DONE);
   assign bus.pass             = (r_state == DONE) && (r_fail == '0);
   assign bus.fail_count       = r_fail;
   assign bus.first_fail       = r_ff;
   assign bus.first_fail_valid = r_ffv;
   assign bus.captured         = r_cap;
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: table-driven runs plus abort, ignored-start and SETTLE=1 sequences.
module tb_truth_table_checker;
   logic clk = 1'b0;
   logic nrst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic [1:0] mode = 2'd0;
   always #5 clk = ~clk;
   truth_table_checker_if #(.N_IN(4)) bus1 ();
   truth_table_checker_if #(.N_IN(4)) bus2 ();
   truth_table_checker #(.N_IN(4), .SETTLE(10)) dut1 (.clk(clk), .nrst(nrst), .bus(bus1.slave));
   truth_table_checker #(.N_IN(4), .SETTLE(1))  dut2 (.clk(clk), .nrst(nrst), .bus(bus2.slave));
   // reference DUT behaviours: 0 xor, 1 tied 0, 2 A&D, 3 xnor
   always_comb begin
      bus1.dut_out = (mode == 2'd0) ? ^bus1.vec_out
                   : (mode == 2'd1) ? 1'b0
                   : (mode == 2'd2) ? (bus1.vec_out[3] & bus1.vec_out[0])
                   : ~^bus1.vec_out;
      bus2.dut_out = ^bus2.vec_out;
   end
   typedef struct {
      logic [1:0]  mode;
      logic [15:0] exp;
      logic [15:0] cap;
      logic [4:0]  fc;
      logic [3:0]  ff;
      logic        ffv;
      logic        pass;
   } vec_t;
   vec_t tbl [6];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, " vec_out"}, 32'(bus1.vec_out), 0);
      chk({tag, " busy"}, 32'(bus1.busy), 0);
      chk({tag, " done"}, 32'(bus1.done), 0);
      chk({tag, " pass"}, 32'(bus1.pass), 0);
      chk({tag, " fail_count"}, 32'(bus1.fail_count), 0);
      chk({tag, " first_fail"}, 32'(bus1.first_fail), 0);
      chk({tag, " first_fail_valid"}, 32'(bus1.first_fail_valid), 0);
      chk({tag, " captured"}, 32'(bus1.captured), 0);
   endtask
   task automatic chk_res(input string tag, input vec_t t);
      chk({tag, " done"}, 32'(bus1.done), 1);
      chk({tag, " busy"}, 32'(bus1.busy), 0);
      chk({tag, " pass"}, 32'(bus1.pass), 32'(t.pass));
      chk({tag, " fail_count"}, 32'(bus1.fail_count), 32'(t.fc));
      chk({tag, " first_fail"}, 32'(bus1.first_fail), 32'(t.ff));
      chk({tag, " first_fail_valid"}, 32'(bus1.first_fail_valid), 32'(t.ffv));
      chk({tag, " captured"}, 32'(bus1.captured), 32'(t.cap));
      chk({tag, " vec_out hold"}, 32'(bus1.vec_out), 15);
   endtask
   // issue start; returns after edge E0 (sampled #1 later) with start released
   task automatic kick(input string tag);
      @(negedge clk);
      bus1.start = 1'b1;
      @(posedge clk);
      #1;
      bus1.start = 1'b0;
      chk({tag, " busy at E0"}, 32'(bus1.busy), 1);
      chk({tag, " done at E0"}, 32'(bus1.done), 0);
      chk({tag, " vec_out at E0"}, 32'(bus1.vec_out), 0);
   endtask
   task automatic wait_done(input int already, output int cyc);
      cyc = already;
      while (!bus1.done && cyc < 400) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask
   initial begin
      int cyc;
      bus1.start = 1'b0;
      bus2.start = 1'b0;
      bus1.expected = 16'h6996;
      bus2.expected = 16'h6996;
      tbl[0] = '{2'd0, 16'h6996, 16'h6996, 5'd0,  4'd0,  1'b0, 1'b1};
      tbl[1] = '{2'd1, 16'h6996, 16'h0000, 5'd8,  4'd1,  1'b1, 1'b0};
      tbl[2] = '{2'd2, 16'hAA01, 16'hAA00, 5'd1,  4'd0,  1'b1, 1'b0};
      tbl[3] = '{2'd3, 16'h6996, 16'h9669, 5'd16, 4'd0,  1'b1, 1'b0};
      tbl[4] = '{2'd0, 16'h6997, 16'h6996, 5'd1,  4'd0,  1'b1, 1'b0};
      tbl[5] = '{2'd0, 16'hE996, 16'h6996, 5'd1,  4'd15, 1'b1, 1'b0};
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      nrst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         mode = tbl[i].mode;
         bus1.expected = tbl[i].exp;
         kick($sformatf("vec%0d", i));
         wait_done(0, cyc);
         chk($sformatf("vec%0d cycles", i), 32'(cyc), 160);
         chk_res($sformatf("vec%0d", i), tbl[i]);
      end
      // abort mid-run, then a clean full run
      mode = 2'd1;
      bus1.expected = 16'h6996;
      kick("abort");
      repeat (50) @(posedge clk);
      @(negedge clk);
      nrst = 1'b0;
      @(posedge clk);
      #1;
      chk_zero("abort");
      @(negedge clk);
      nrst = 1'b1;
      mode = 2'd0;
      kick("after abort");
      wait_done(0, cyc);
      chk("after abort cycles", 32'(cyc), 160);
      chk_res("after abort", tbl[0]);
      // start pulse during RUN is ignored
      mode = 2'd1;
      kick("ign");
      repeat (29) @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b1;
      @(posedge clk);
      #1;
      bus1.start = 1'b0;
      chk("ign vec_out at 30", 32'(bus1.vec_out), 3);
      wait_done(30, cyc);
      chk("ign cycles", 32'(cyc), 160);
      chk_res("ign", tbl[1]);
      // restart from DONE reproduces the same result
      kick("restart");
      wait_done(0, cyc);
      chk("restart cycles", 32'(cyc), 160);
      chk_res("restart", tbl[1]);
      // SETTLE=1: one vector per cycle
      @(negedge clk);
      bus2.start = 1'b1;
      @(posedge clk);
      #1;
      bus2.start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("s1 vec_out step %0d", k), 32'(bus2.vec_out), 32'(k));
         chk($sformatf("s1 busy step %0d", k), 32'(bus2.busy), 1);
         @(posedge clk);
         #1;
      end
      chk("s1 done", 32'(bus2.done), 1);
      chk("s1 pass", 32'(bus2.pass), 1);
      chk("s1 fail_count", 32'(bus2.fail_count), 0);
      chk("s1 captured", 32'(bus2.captured), 32'h6996);
      chk("s1 vec_out hold", 32'(bus2.vec_out), 15);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
